// File: rtl/eq_band_gain_mixer.sv
// Per-band gain mixer: captures NUM_BANDS filter outputs, scales each by a Q2.14 gain, sums, rounds, saturates.
// Latency: output_valid rises NUM_BANDS+1 clocks after the capturing enable edge; one shared multiplier.
// Backpressure: none; an enable arriving while a mix is in progress is dropped and flagged on overrun.
module eq_band_gain_mixer #(
  parameter int NUM_BANDS = 3,
  parameter int ADDR_W    = 2,
  parameter int GAIN_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [24*NUM_BANDS-1:0]   band_samples,
  input  logic                      gain_wr_en,
  input  logic [ADDR_W-1:0]         gain_wr_addr,
  input  logic [GAIN_W-1:0]         gain_wr_data,
  output logic [23:0]               output_sample,
  output logic                      output_valid,
  output logic                      sat,
  output logic                      busy,
  output logic                      overrun
);

  localparam int SAMP_W = 24;
  localparam int ACC_W  = 48;
  localparam int PROD_W = SAMP_W + GAIN_W;
  localparam int IDX_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] OUT   = 2'd2;

  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_BANDS - 1);
  localparam logic signed [GAIN_W-1:0] UNITY    = GAIN_W'(16384);
  localparam logic signed [ACC_W-1:0]  RND_HALF = 48'sd8192;
  localparam logic signed [ACC_W-1:0]  SAT_MAX  = 48'sd8388607;
  localparam logic signed [ACC_W-1:0]  SAT_MIN  = -48'sd8388608;

  logic [1:0]               state;
  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc;

  logic signed [SAMP_W-1:0] samp_lat [NUM_BANDS];
  logic signed [GAIN_W-1:0] gain_reg [NUM_BANDS];
  logic signed [GAIN_W-1:0] gain_act [NUM_BANDS];

  logic                     capture;
  logic signed [SAMP_W-1:0] mul_a;
  logic signed [GAIN_W-1:0] mul_b;
  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  product_ext;
  logic signed [ACC_W-1:0]  acc_rnd;
  logic signed [ACC_W-1:0]  acc_shr;
  logic                     clip_hi;
  logic                     clip_lo;
  logic [SAMP_W-1:0]        result;

  assign capture = (state == IDLE) && enable;
  assign busy    = (state != IDLE);

  // Shared multiplier: operands are selected by the running band index.
  always_comb begin
    mul_a       = samp_lat[idx];
    mul_b       = gain_act[idx];
    product     = mul_a * mul_b;
    product_ext = {{(ACC_W - PROD_W){product[PROD_W-1]}}, product};
  end

  // Round half up back to Q0, then clip to the 24-bit signed range.
  always_comb begin
    acc_rnd = acc + RND_HALF;
    acc_shr = acc_rnd >>> 14;
    clip_hi = (acc_shr > SAT_MAX);
    clip_lo = (acc_shr < SAT_MIN);
    if (clip_hi) begin
      result = SAMP_W'(SAT_MAX);
    end else if (clip_lo) begin
      result = SAMP_W'(SAT_MIN);
    end else begin
      result = acc_shr[SAMP_W-1:0];
    end
  end

  // Programmable gain registers; out-of-range addresses are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        gain_reg[k] <= UNITY;
      end
    end else if (gain_wr_en && (int'(gain_wr_addr) < NUM_BANDS)) begin
      gain_reg[gain_wr_addr] <= gain_wr_data;
    end
  end

  // Capture samples and freeze the gain set so a mix never sees a half-updated gain table.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        samp_lat[k] <= '0;
        gain_act[k] <= UNITY;
      end
    end else if (capture) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        samp_lat[k] <= band_samples[SAMP_W*k +: SAMP_W];
        gain_act[k] <= gain_reg[k];
      end
    end
  end

  // Sequencer: one multiply-accumulate per band, then one cycle to publish the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            idx   <= '0;
            acc   <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc + product_ext;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state <= OUT;
          end
        end
        OUT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output register: sample holds between mixes; valid, sat and overrun are single-cycle pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      output_sample <= '0;
      output_valid  <= 1'b0;
      sat           <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      output_valid <= (state == OUT);
      sat          <= (state == OUT) && (clip_hi || clip_lo);
      overrun      <= enable && (state != IDLE);
      if (state == OUT) begin
        output_sample <= result;
      end
    end
  end

endmodule

// File: doc/eq_band_gain_mixer.md
Name: eq_band_gain_mixer

Overview:
- Downstream stage of the per-band FIR filters in the equalizer.
- Captures one 24-bit output sample from each of NUM_BANDS filters on a sample strobe, applies a programmable signed gain per band, and sums the results.
- Uses a single time-multiplexed multiplier, then rounds and saturates to one 24-bit equalized sample with a one-cycle valid pulse.
- Output feeds the DAC/serializer path.

Parameters:
- NUM_BANDS, 3, number of band inputs (1..256).
- ADDR_W, 2, gain write address width; must satisfy 2^ADDR_W >= NUM_BANDS.
- GAIN_W, 16, gain width, signed Q2.14 (16384 = unity).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  sample strobe, one clk wide, band_samples valid when high.
- band_samples  input  24*NUM_BANDS  signed band outputs; band k at [24k+23:24k].
- gain_wr_en  input  1  gain register write strobe.
- gain_wr_addr  input  ADDR_W  band index to write.
- gain_wr_data  input  GAIN_W  signed Q2.14 gain.
- output_sample  output  24  signed mixed sample, held between updates.
- output_valid  output  1  one-cycle pulse when output_sample updates.
- sat  output  1  pulses with output_valid if the result was clipped.
- busy  output  1  high while a mix is in progress.
- overrun  output  1  one-cycle pulse when enable is ignored because busy.

Behaviour:
- Clock and reset: one clock domain, clk. reset_n is asynchronous and active-low.
- Reset values: output_sample=0, output_valid=0, sat=0, busy=0, overrun=0, state=IDLE, accumulator=0, all gain registers and active gains=16384.
- Reset mid-operation: the in-flight mix is discarded and no output_valid is produced.
- Gain registers:
  - Written on any edge with gain_wr_en=1.
  - Writes with gain_wr_addr >= NUM_BANDS are ignored.
- Gain snapshot: at the capture edge, all gain registers are copied to an active-gain set used for the whole mix.
  - A write on the same edge as capture is not seen by that mix.
  - A write during ACCUM/OUT affects only later mixes.
- FSM states IDLE, ACCUM, OUT:
  - IDLE, enable=1 (edge E0): latch band_samples, snapshot gains, clear the accumulator and band index, go to ACCUM.
  - ACCUM (edges E1..E_NUM_BANDS): acc += sample[idx]*gain[idx], idx++. After the edge where idx=NUM_BANDS-1, go to OUT.
  - OUT (edge E_NUM_BANDS+1): register the rounded/saturated result, output_valid=1 and sat for one cycle, go to IDLE.
- busy: equals (state != IDLE), so it is high for NUM_BANDS+1 cycles after E0.
- Latency: output_valid is high in the cycle after edge E_NUM_BANDS+1 (4 clocks after E0 for NUM_BANDS=3).
- Throughput: enable is accepted again in the cycle output_valid is high, giving a minimum sample period of NUM_BANDS+2 clocks.
- enable while busy: ignored, overrun=1 for that cycle, the current mix is unaffected.
- Arithmetic:
  - Products are 24x16 signed into a 48-bit signed accumulator; no internal overflow for NUM_BANDS<=256.
  - Result = (acc + 2^13) >>> 14 (round half up).
  - Saturate to [-8388608, 8388607]; sat=1 if clipping occurred.
- output_sample changes only on output_valid cycles.

Test Plan:
- Unity mix: after reset, no writes, band_samples = {-500, 2000, 1000} (band2..band0), enable pulse.
  - Required: output_sample=2500, sat=0, output_valid exactly 4 clocks after the enable edge, busy high for 4 cycles.
- Programmed gains: write band0=8192, band1=0, band2=-16384; bands 1001, 7777, 300 (band0..band2).
  - Required: output_sample=201 (200.5 rounded up), sat=0.
- Saturation: all gains=32767, all bands=8388607.
  - Required: output_sample=8388607, sat=1.
  - Then all bands=-8388608: output_sample=-8388608, sat=1.
- Overrun: enable, then a second enable 2 clocks later.
  - Required: overrun pulses once, only one output_valid, result from the first capture.
  - An enable in the output_valid cycle is accepted (busy=1 next cycle).
- Gain coherency: write band0=0 one clock after capture of bands {0, 0, 100} at unity.
  - Required: this mix outputs 100; the next mix of the same data outputs 0.
  - A write to addr=3 changes nothing.
- Reset mid-ACCUM: drop reset_n for one clock during a mix.
  - Required: immediately output_sample=0, busy=0, no output_valid.
  - The next mix uses unity gains and is correct.
